ascii_uart_tx: RTL

Buffered UART transmitter that consumes the ASCII byte stream produced by the matrix readout path. It is the stage directly downstream of the all-matrices reader. It accepts bytes over a valid/ready handshake into a small FIFO and serialises them as 8N1 frames on the board TX pin. This decouples the reader's burst rate from the line rate.

---
 rtl/ascii_uart_tx.sv | 88 ++++++++
 1 files changed

// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx: FIFO-buffered 8N1 UART transmitter for the ASCII readout byte stream
module ascii_uart_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  ascii_data,
  input  logic                        ascii_valid,
  output logic                        ascii_ready,
  output logic                        uart_tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("ascii_uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ascii_uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0] shifter, shifter_n;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic push, pop, baud_wrap, tx_n;
  assign ascii_ready = rst_n && (fifo_level != (AW+1)'(FIFO_DEPTH));
  assign push = ascii_valid && ascii_ready;
  assign pop = (state == IDLE) && (fifo_level != '0);
  assign baud_wrap = baud_cnt == CW'(CLKS_PER_BIT - 1);
  assign tx_busy = (state != IDLE) || (fifo_level != '0);
  always_comb begin
    state_n = state;
    shifter_n = shifter;
    bit_idx_n = bit_idx;
    baud_cnt_n = baud_wrap ? '0 : baud_cnt + 1'b1;
    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        bit_idx_n = '0;
        if (pop) begin
          state_n = START;
          shifter_n = mem[rd_ptr];
        end
      end
      START: state_n = baud_wrap ? DATA : START;
      DATA: if (baud_wrap) begin
        shifter_n = shifter >> 1;
        bit_idx_n = bit_idx + 3'd1;
        state_n = (bit_idx == 3'd7) ? STOP : DATA;
      end
      STOP: state_n = baud_wrap ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    // the line is registered, so it is driven from the state being entered
    tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? shifter_n[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      shifter <= '0;
      baud_cnt <= '0;
      bit_idx <= '0;
      uart_tx <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
    end else begin
      state <= state_n;
      shifter <= shifter_n;
      baud_cnt <= baud_cnt_n;
      bit_idx <= bit_idx_n;
      uart_tx <= tx_n;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ascii_data;
  end
endmodule
